branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2: number of cycles younger EX-stage slots are squashed after a redirect (legal 1..7).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port ex_valid  in  1  EX slot holds a live instruction.
REQ-005 SHALL have port ex_instr  in  32  instruction in EX.
REQ-006 SHALL have port ex_pc  in  32  PC of ex_instr.
REQ-007 SHALL have ports rs1_data, rs2_data  in  32 each  forwarded source operands.
REQ-008 SHALL have port pred_taken  in  1  fetch-stage taken prediction for this instruction.
REQ-009 SHALL have port pred_target  in  32  fetch-stage next PC for this instruction.
REQ-010 SHALL have port is_b_jump  out  1  registered; resolved B-type taken.
REQ-011 SHALL have port redirect_valid  out  1  one-cycle fetch redirect pulse.
REQ-012 SHALL have port redirect_pc  out  32  correct next PC, valid with redirect_valid.
REQ-013 SHALL have port squash  out  1  kill younger in-flight instructions.
REQ-014 SHALL have ports link_valid  out  1, link_data  out  32  rd write-back of ex_pc+4 for JAL/JALR.
REQ-015 SHALL have ports perf_branches, perf_mispredicts  out  32 each  statistics counters.

Function
REQ-016 SHALL decode opcode 1100011 as B, 1101111 as JAL, 1100111 as JALR; all others non-control.
REQ-017 SHALL resolve B funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; funct3 010/011 treated as non-control.
REQ-018 SHALL compute targets modulo 2^32: B ex_pc+imm_b, JAL ex_pc+imm_j, JALR (rs1_data+imm_i) with bit0 cleared; fall-through ex_pc+4.
REQ-019 SHALL flag mispredict: B when taken!=pred_taken, or taken and target!=pred_target; JALR always; JAL and non-control never.
REQ-020 SHALL act on an instruction only when ex_valid=1 and squash=0 (accepted); otherwise it has no effect on any output or counter.
REQ-021 SHALL implement state machine RUN/FLUSH; RUN->FLUSH on accepted mispredict; FLUSH->RUN after FLUSH_DEPTH cycles.
REQ-022 SHALL, one cycle after an accepted mispredict, assert redirect_valid for exactly one cycle with redirect_pc = actual next PC (target if taken, else ex_pc+4).
REQ-023 SHALL assert squash for exactly FLUSH_DEPTH consecutive cycles, beginning the cycle redirect_valid asserts.
REQ-024 SHALL drive is_b_jump one cycle after an accepted B-type, 1 if taken, else 0; 0 in all other cycles.
REQ-025 SHALL drive link_valid/link_data one cycle after an accepted JAL/JALR with rd!=0; link_valid=0 otherwise.
REQ-026 SHALL ignore a mispredict presented in any FLUSH cycle, including the last; no second redirect results.
REQ-027 SHALL accept back-to-back control instructions in RUN, one per cycle, with no bubbles absent mispredicts.

Reset
REQ-028 SHALL, while rst=1, force state RUN, flush counter 0, and is_b_jump, redirect_valid, squash, link_valid to 0, redirect_pc, link_data, perf counters to 0.
REQ-029 SHALL abort an in-progress FLUSH on rst; first cycle after rst deasserts is RUN with squash=0.

Configuration
REQ-030 SHALL, with BRU_PERF_CNT_EN defined, increment perf_branches per accepted B-type and perf_mispredicts per accepted mispredict, wrapping at 2^32.
REQ-031 SHALL, without BRU_PERF_CNT_EN, keep both perf ports present, tied to 0, with no counter logic.

Verification
REQ-032 BEQ, rs1=rs2=5, ex_pc=0x100, imm=+16, pred_taken=1, pred_target=0x110 -> next cycle is_b_jump=1, redirect_valid=0, squash=0.
REQ-033 BNE, rs1=rs2=3, pred_taken=1 at ex_pc=0x200 -> redirect_valid=1, redirect_pc=0x204, squash=1 for 2 cycles, then RUN.
REQ-034 JALR rs1=0x1003, imm=+4, rd=1, ex_pc=0x40 -> redirect_pc=0x1006, link_valid=1, link_data=0x44.
REQ-035 Mispredicting BLT during 2nd squash cycle -> no redirect, is_b_jump=0, perf_mispredicts unchanged.
REQ-036 rst=1 in 1st squash cycle -> next cycle squash=0, redirect_valid=0, perf counters 0; BLTU 0xFFFFFFFF<1 afterward resolves not-taken.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Branch-resolve bus: EX-stage operands in, fetch redirect / squash /
// link write-back / statistics out. The master drives the EX slot, the
// slave (branch_resolve) drives the results.
interface branch_resolve_if;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        is_b_jump;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        squash;
    logic        link_valid;
    logic [31:0] link_data;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    modport master (
        output ex_valid, ex_instr, ex_pc, rs1_data, rs2_data, pred_taken, pred_target,
        input  is_b_jump, redirect_valid, redirect_pc, squash, link_valid, link_data,
               perf_branches, perf_mispredicts
    );

    modport slave (
        input  ex_valid, ex_instr, ex_pc, rs1_data, rs2_data, pred_taken, pred_target,
        output is_b_jump, redirect_valid, redirect_pc, squash, link_valid, link_data,
               perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution for an RV32 pipeline.
// Resolves B-type/JAL/JALR, detects mispredicts against the fetch
// prediction, issues a one-cycle redirect and squashes younger slots for
// FLUSH_DEPTH cycles. Optional statistics counters: define
// BRU_PERF_CNT_EN to build them; otherwise the perf ports read 0.
module branch_resolve #(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_resolve_if.slave   bus
);
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_DEPTH - 1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        squash_r, squash_s;
    logic        redirect_r, redirect_s;
    logic [31:0] redirect_pc_r, redirect_pc_s;
    logic        is_b_jump_r, is_b_jump_s;
    logic        link_valid_r, link_valid_s;
    logic [31:0] link_data_r, link_data_s;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_i_s, imm_b_s, imm_j_s;
    logic        is_b_s, is_jal_s, is_jalr_s;
    logic        cond_s, taken_s, mispred_s, accepted_s;
    logic [31:0] target_s, fall_s, next_pc_s;

    assign opcode_s = bus.ex_instr[6:0];
    assign funct3_s = bus.ex_instr[14:12];
    assign rd_s     = bus.ex_instr[11:7];
    assign imm_i_s  = {{20{bus.ex_instr[31]}}, bus.ex_instr[31:20]};
    assign imm_b_s  = {{19{bus.ex_instr[31]}}, bus.ex_instr[31], bus.ex_instr[7],
                       bus.ex_instr[30:25], bus.ex_instr[11:8], 1'b0};
    assign imm_j_s  = {{11{bus.ex_instr[31]}}, bus.ex_instr[31], bus.ex_instr[19:12],
                       bus.ex_instr[20], bus.ex_instr[30:21], 1'b0};
    assign fall_s   = bus.ex_pc + 32'd4;
    // A slot presented while squashing belongs to the wrong path.
    assign accepted_s = bus.ex_valid & ~squash_r;

    // Decode the EX instruction, evaluate the branch condition and target.
    always_comb begin
        is_b_s    = 1'b0;
        is_jal_s  = 1'b0;
        is_jalr_s = 1'b0;
        cond_s    = 1'b0;
        target_s  = fall_s;
        case (funct3_s)
            3'b000:  cond_s = (bus.rs1_data == bus.rs2_data);
            3'b001:  cond_s = (bus.rs1_data != bus.rs2_data);
            3'b100:  cond_s = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'b101:  cond_s = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'b110:  cond_s = (bus.rs1_data <  bus.rs2_data);
            3'b111:  cond_s = (bus.rs1_data >= bus.rs2_data);
            default: cond_s = 1'b0;
        endcase
        case (opcode_s)
            OP_B: begin
                // funct3 010/011 are not branches; leave them non-control.
                is_b_s   = (funct3_s != 3'b010) && (funct3_s != 3'b011);
                target_s = bus.ex_pc + imm_b_s;
            end
            OP_JAL: begin
                is_jal_s = 1'b1;
                target_s = bus.ex_pc + imm_j_s;
            end
            OP_JALR: begin
                is_jalr_s = 1'b1;
                target_s  = (bus.rs1_data + imm_i_s) & 32'hFFFF_FFFE;
            end
            default: target_s = fall_s;
        endcase
        if (is_b_s) begin
            taken_s   = cond_s;
            mispred_s = (cond_s != bus.pred_taken) ||
                        (cond_s && (target_s != bus.pred_target));
        end else begin
            taken_s   = is_jal_s | is_jalr_s;
            // JAL is resolved at fetch; JALR's operand is only known here.
            mispred_s = is_jalr_s;
        end
        next_pc_s = taken_s ? target_s : fall_s;
    end

    // Next-state and next-output logic for the RUN/FLUSH sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        redirect_s    = 1'b0;
        redirect_pc_s = redirect_pc_r;
        is_b_jump_s   = accepted_s & is_b_s & taken_s;
        link_valid_s  = accepted_s & (is_jal_s | is_jalr_s) & (rd_s != 5'd0);
        link_data_s   = link_valid_s ? fall_s : 32'd0;
        case (state_r)
            ST_RUN: begin
                if (accepted_s && mispred_s) begin
                    state_s       = ST_FLUSH;
                    cnt_s         = CNT_INIT;
                    redirect_s    = 1'b1;
                    redirect_pc_s = next_pc_s;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == 3'd0) begin
                    state_s = ST_RUN;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 3'd0;
            end
        endcase
        squash_s = (state_s == ST_FLUSH);
    end

    // State and registered outputs; reset aborts any flush in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            cnt_r         <= 3'd0;
            squash_r      <= 1'b0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            is_b_jump_r   <= 1'b0;
            link_valid_r  <= 1'b0;
            link_data_r   <= 32'd0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            squash_r      <= squash_s;
            redirect_r    <= redirect_s;
            redirect_pc_r <= redirect_pc_s;
            is_b_jump_r   <= is_b_jump_s;
            link_valid_r  <= link_valid_s;
            link_data_r   <= link_data_s;
        end
    end

    assign bus.squash         = squash_r;
    assign bus.redirect_valid = redirect_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.is_b_jump      = is_b_jump_r;
    assign bus.link_valid     = link_valid_r;
    assign bus.link_data      = link_data_r;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_r;
    logic [31:0] perf_mispredicts_r;

    // Count accepted branches and accepted mispredicts, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_r    <= 32'd0;
            perf_mispredicts_r <= 32'd0;
        end else begin
            if (accepted_s && is_b_s) begin
                perf_branches_r <= perf_branches_r + 32'd1;
            end
            if (accepted_s && mispred_s && (state_r == ST_RUN)) begin
                perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
            end
        end
    end

    assign bus.perf_branches    = perf_branches_r;
    assign bus.perf_mispredicts = perf_mispredicts_r;
`else
    assign bus.perf_branches    = 32'd0;
    assign bus.perf_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve (FLUSH_DEPTH = 2).
module tb_branch_resolve;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    branch_resolve_if bus ();

    branch_resolve #(.FLUSH_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef BRU_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pexp(input logic [31:0] n);
        return PERF_ON ? n : 32'd0;
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic [31:0] ptgt);
        bus.ex_valid    = v;
        bus.ex_instr    = instr;
        bus.ex_pc       = pc;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
        bus.pred_taken  = pt;
        bus.pred_target = ptgt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        cyc();
        chk("rst_squash",    {31'd0, bus.squash},         32'd0);
        chk("rst_redirect",  {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_rpc",       bus.redirect_pc,             32'd0);
        chk("rst_bjump",     {31'd0, bus.is_b_jump},      32'd0);
        chk("rst_link",      {31'd0, bus.link_valid},     32'd0);
        chk("rst_ldata",     bus.link_data,               32'd0);
        chk("rst_pbr",       bus.perf_branches,           32'd0);
        chk("rst_pmis",      bus.perf_mispredicts,        32'd0);
        rst = 1'b0;
        cyc();

        // BEQ taken, correctly predicted
        drive(1'b1, enc_b(3'b000, 13'd16), 32'h100, 32'd5, 32'd5, 1'b1, 32'h110);
        cyc();
        chk("beq_bjump",    {31'd0, bus.is_b_jump},      32'd1);
        chk("beq_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("beq_squash",   {31'd0, bus.squash},         32'd0);

        // JAL rd=1 back to back, never a mispredict
        drive(1'b1, enc_jal(5'd1, 21'h20), 32'h300, 32'd0, 32'd0, 1'b0, 32'h0);
        cyc();
        chk("jal_link",     {31'd0, bus.link_valid},     32'd1);
        chk("jal_ldata",    bus.link_data,               32'h304);
        chk("jal_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("jal_bjump",    {31'd0, bus.is_b_jump},      32'd0);
        chk("jal_pbr",      bus.perf_branches,           pexp(32'd1));

        // JAL rd=0: no link write
        drive(1'b1, enc_jal(5'd0, 21'h8), 32'h320, 32'd0, 32'd0, 1'b1, 32'h328);
        cyc();
        chk("jal0_link",    {31'd0, bus.link_valid},     32'd0);

        // BGE signed: -1 >= 1 false, predicted not taken
        drive(1'b1, enc_b(3'b101, 13'd8), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h404);
        cyc();
        chk("bge_bjump",    {31'd0, bus.is_b_jump},      32'd0);
        chk("bge_redirect", {31'd0, bus.redirect_valid}, 32'd0);

        // BGEU: 0xFFFFFFFF >= 1 true, predicted taken to 0x408
        drive(1'b1, enc_b(3'b111, 13'd8), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h408);
        cyc();
        chk("bgeu_bjump",   {31'd0, bus.is_b_jump},      32'd1);
        chk("bgeu_redirect",{31'd0, bus.redirect_valid}, 32'd0);

        // Non-control: ADD opcode and B opcode with funct3 010
        drive(1'b1, 32'h0020_80B3, 32'h410, 32'd1, 32'd2, 1'b1, 32'h999);
        cyc();
        chk("alu_bjump",    {31'd0, bus.is_b_jump},      32'd0);
        chk("alu_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        drive(1'b1, enc_b(3'b010, 13'd8), 32'h414, 32'd1, 32'd1, 1'b1, 32'h41C);
        cyc();
        chk("f3_010_redir", {31'd0, bus.redirect_valid}, 32'd0);
        chk("f3_010_pbr",   bus.perf_branches,           pexp(32'd3));

        // Mispredicting BNE with ex_valid=0 has no effect
        drive(1'b0, enc_b(3'b001, 13'd64), 32'h200, 32'd3, 32'd3, 1'b1, 32'h240);
        cyc();
        chk("inv_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("inv_squash",   {31'd0, bus.squash},         32'd0);

        // BNE not taken but predicted taken -> redirect to 0x204, squash 2 cycles
        drive(1'b1, enc_b(3'b001, 13'd64), 32'h200, 32'd3, 32'd3, 1'b1, 32'h240);
        cyc();
        chk("bne_redirect", {31'd0, bus.redirect_valid}, 32'd1);
        chk("bne_rpc",      bus.redirect_pc,             32'h204);
        chk("bne_squash1",  {31'd0, bus.squash},         32'd1);
        chk("bne_bjump",    {31'd0, bus.is_b_jump},      32'd0);
        chk("bne_pbr",      bus.perf_branches,           pexp(32'd4));
        chk("bne_pmis",     bus.perf_mispredicts,        pexp(32'd1));
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        chk("bne_redir2",   {31'd0, bus.redirect_valid}, 32'd0);
        chk("bne_squash2",  {31'd0, bus.squash},         32'd1);
        cyc();
        chk("bne_squash3",  {31'd0, bus.squash},         32'd0);

        // JALR: (0x1003 + 4) & ~1 = 0x1006, link 0x44
        drive(1'b1, enc_jalr(5'd1, 12'd4), 32'h40, 32'h1003, 32'd0, 1'b1, 32'h1006);
        cyc();
        chk("jalr_redirect",{31'd0, bus.redirect_valid}, 32'd1);
        chk("jalr_rpc",     bus.redirect_pc,             32'h1006);
        chk("jalr_link",    {31'd0, bus.link_valid},     32'd1);
        chk("jalr_ldata",   bus.link_data,               32'h44);
        chk("jalr_squash",  {31'd0, bus.squash},         32'd1);
        chk("jalr_pmis",    bus.perf_mispredicts,        pexp(32'd2));

        // Mispredicting BLT (-5 < 3 taken, predicted not taken) in squash cycle 1
        drive(1'b1, enc_b(3'b100, 13'd32), 32'h500, 32'hFFFF_FFFB, 32'd3, 1'b0, 32'h504);
        cyc();
        chk("blt1_redirect",{31'd0, bus.redirect_valid}, 32'd0);
        chk("blt1_bjump",   {31'd0, bus.is_b_jump},      32'd0);
        chk("blt1_link",    {31'd0, bus.link_valid},     32'd0);
        chk("blt1_squash",  {31'd0, bus.squash},         32'd1);
        // Same BLT in squash cycle 2 (the last)
        cyc();
        chk("blt2_redirect",{31'd0, bus.redirect_valid}, 32'd0);
        chk("blt2_bjump",   {31'd0, bus.is_b_jump},      32'd0);
        chk("blt2_squash",  {31'd0, bus.squash},         32'd0);
        chk("blt2_pmis",    bus.perf_mispredicts,        pexp(32'd2));
        chk("blt2_pbr",     bus.perf_branches,           pexp(32'd4));
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        chk("blt_after_redir", {31'd0, bus.redirect_valid}, 32'd0);

        // Mispredict, then reset during squash cycle 1
        drive(1'b1, enc_b(3'b001, 13'd16), 32'h600, 32'd7, 32'd7, 1'b1, 32'h610);
        cyc();
        chk("pre_rst_squash", {31'd0, bus.squash},       32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_squash",  {31'd0, bus.squash},         32'd0);
        chk("rst2_redirect",{31'd0, bus.redirect_valid}, 32'd0);
        chk("rst2_pbr",     bus.perf_branches,           32'd0);
        chk("rst2_pmis",    bus.perf_mispredicts,        32'd0);

        // BLTU 0xFFFFFFFF < 1 is false; predicted not taken
        drive(1'b1, enc_b(3'b110, 13'd16), 32'h700, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h704);
        cyc();
        chk("bltu_bjump",   {31'd0, bus.is_b_jump},      32'd0);
        chk("bltu_redirect",{31'd0, bus.redirect_valid}, 32'd0);
        chk("bltu_squash",  {31'd0, bus.squash},         32'd0);
        chk("bltu_pbr",     bus.perf_branches,           pexp(32'd1));
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
